// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse round datapath.
// The multiply helpers are built only from chained xtime. They use no tables and no generic multipliers.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int unsigned AES_COLS = 4;

  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Each gmulN shares its xtime chain internally, so the depth stays at three xtime levels.
  function automatic logic [7:0] gmul9(input logic [7:0] a);
    logic [7:0] x1, x2, x3;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return x3 ^ a;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] a);
    logic [7:0] x1, x2, x3;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return x3 ^ x1 ^ a;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] a);
    logic [7:0] x1, x2, x3;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return x3 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] a);
    logic [7:0] x1, x2, x3;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return x3 ^ x2 ^ x1;
  endfunction

  function automatic aes_col_t get_col(input aes_state_t s, input int unsigned c);
    return s[127 - 32*c -: 32];
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit column. Row 0 is in the MSB byte.
module inv_mix_column
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  output aes_col_t col_o
);

  logic [7:0] a0_s, a1_s, a2_s, a3_s;
  logic [7:0] b0_s, b1_s, b2_s, b3_s;

  always_comb begin
    a0_s = col_i[31:24];
    a1_s = col_i[23:16];
    a2_s = col_i[15:8];
    a3_s = col_i[7:0];
    b0_s = gmul14(a0_s) ^ gmul11(a1_s) ^ gmul13(a2_s) ^ gmul9(a3_s);
    b1_s = gmul9(a0_s)  ^ gmul14(a1_s) ^ gmul11(a2_s) ^ gmul13(a3_s);
    b2_s = gmul13(a0_s) ^ gmul9(a1_s)  ^ gmul14(a2_s) ^ gmul11(a3_s);
    b3_s = gmul11(a0_s) ^ gmul13(a1_s) ^ gmul9(a2_s)  ^ gmul14(a3_s);
    col_o = {b0_s, b1_s, b2_s, b3_s};
  end

endmodule

// File: rtl/inv_mix_columns.sv
// Registered InvMixColumns stage. Four column transforms feed one 128-bit output register.
// The output is cleared asynchronously while reset is high.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] IN_DATA,
  output logic [127:0] INV_MIXED_DATA
);

  aes_state_t inv_mixed_d;
  aes_state_t inv_mixed_q;

  for (genvar c = 0; c < AES_COLS; c++) begin : g_col
    inv_mix_column u_col (
      .col_i (get_col(IN_DATA, c)),
      .col_o (inv_mixed_d[127 - 32*c -: 32])
    );
  end

  // The output register. A reset discards any result still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_mixed_q <= 128'h0;
    end else begin
      inv_mixed_q <= inv_mixed_d;
    end
  end

  assign INV_MIXED_DATA = inv_mixed_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns. The reference uses a generic GF(2^8) multiply and a circulant matrix.
module tb_inv_mix_columns;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] IN_DATA = 128'h0;
  logic [127:0] INV_MIXED_DATA;

  int passed = 0;
  int total  = 0;

  inv_mix_columns dut (
    .clk            (clk),
    .rst            (rst),
    .IN_DATA        (IN_DATA),
    .INV_MIXED_DATA (INV_MIXED_DATA)
  );

  always #5 clk = ~clk;

  // Multiply by carry-less product and then reduce modulo 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Apply a circulant matrix to each column. The coefficient for output row r and input row j is row0[(j-r) mod 4].
  function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [31:0] row0);
    logic [127:0] o;
    logic [7:0]   acc, coef, a;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          coef = row0[31 - 8*((j - r + 4) % 4) -: 8];
          a    = s[127 - 8*(4*c + j) -: 8];
          acc  = acc ^ gf_mul(coef, a);
        end
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    return mat_apply(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    return mat_apply(s, 32'h02030101);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  localparam logic [127:0] V_RST = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V1_IN = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] V1_EX = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] V2_IN = 128'hd5d5d7d64d7ebdf800000000ffffffff;
  localparam logic [127:0] V2_EX = 128'hd4d4d4d52d26314c00000000ffffffff;

  logic [127:0] orig, mixed, prev;

  initial begin
    // The reset value must appear immediately and stay while reset is held.
    IN_DATA = V_RST;
    #2;
    check("reset_immediate", INV_MIXED_DATA, 128'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_held", INV_MIXED_DATA, 128'h0);
    end
    rst = 1'b0;
    #1;
    check("reset_release_no_edge", INV_MIXED_DATA, 128'h0);

    // Directed vectors are applied on consecutive edges.
    IN_DATA = V1_IN;
    @(posedge clk); #1;
    check("fips_vec", INV_MIXED_DATA, V1_EX);
    check("fips_vec_model", INV_MIXED_DATA, ref_inv(V1_IN));
    IN_DATA = V2_IN;
    #1;
    check("no_comb_path", INV_MIXED_DATA, V1_EX);
    @(posedge clk); #1;
    check("col_indep_vec", INV_MIXED_DATA, V2_EX);

    // Zero input and uniform columns are fixed points.
    IN_DATA = 128'h0;
    @(posedge clk); #1;
    check("all_zero", INV_MIXED_DATA, 128'h0);
    IN_DATA = 128'h5a5a5a5a_ffffffff_01010101_80808080;
    @(posedge clk); #1;
    check("uniform_cols", INV_MIXED_DATA, 128'h5a5a5a5a_ffffffff_01010101_80808080);

    // Round trip: inverting the reference forward MixColumns must restore the original state.
    for (int n = 0; n < 1000; n++) begin
      orig    = {$urandom, $urandom, $urandom, $urandom};
      mixed   = ref_fwd(orig);
      IN_DATA = mixed;
      @(posedge clk); #1;
      check("round_trip", INV_MIXED_DATA, orig);
    end

    // A reset between two inputs must discard the pending result.
    IN_DATA = V1_IN;
    @(posedge clk); #1;
    check("pre_midreset", INV_MIXED_DATA, V1_EX);
    IN_DATA = V2_IN;
    #1 rst = 1'b1;
    #1;
    check("midreset_immediate", INV_MIXED_DATA, 128'h0);
    @(posedge clk); #1;
    check("midreset_held", INV_MIXED_DATA, 128'h0);
    prev    = {$urandom, $urandom, $urandom, $urandom};
    IN_DATA = prev;
    #1 rst = 1'b0;
    #1;
    check("midreset_released", INV_MIXED_DATA, 128'h0);
    @(posedge clk); #1;
    check("after_release", INV_MIXED_DATA, ref_inv(prev));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
